// File: rtl/mem_interface_pkg.sv
// rtl/mem_interface_pkg.sv - shared CPU constants: sequencer state encoding and bus-mux selects
package mem_interface_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bus-mux encoder codes; the MDR drives the mux input selected by MDR_SEL.
  localparam logic [4:0] PC_SEL  = 5'd0;
  localparam logic [4:0] IR_SEL  = 5'd1;
  localparam logic [4:0] MDR_SEL = 5'd2;
  localparam logic [4:0] ALU_SEL = 5'd3;

endpackage

// File: rtl/mem_interface_mdr_reg.sv
// rtl/mem_interface_mdr_reg.sv - 32-bit MDR with bus/memory load select and async clear
module mem_interface_mdr_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_bus,
  input  logic [31:0] bus_in,
  input  logic        load_mem,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data_q
);

  // Memory capture wins; the sequencer never asserts both loads in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load_mem) begin
      data_q <= mem_rdata;
    end else if (load_bus) begin
      data_q <= bus_in;
    end
  end

endmodule

// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - MAR/MDR pair and single-word memory handshake sequencer
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  output logic [31:0]       mdr_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  // Only the word-address bits of the MAR are ever observable, so only they are kept.
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              mdr_load_bus;
  logic              mdr_load_mem;

  always_comb begin
    state_d      = state_q;
    mar_d        = mar_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    err_d        = err_q;
    mdr_load_bus = 1'b0;
    mdr_load_mem = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mar_in) mar_d = bus_in[ADDR_W-1:0];
        mdr_load_bus = mdr_in;
        if (read ^ write) begin
          state_d = ST_REQ;
          we_d    = write;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (read && write) begin
          err_d = 1'b1;
        end
      end
      ST_REQ: begin
        // Ack is checked first so an ack on the last allowed cycle still succeeds.
        if (mem_ack) begin
          mdr_load_mem = ~we_q;
          state_d      = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (mar_in) mar_d = bus_in[ADDR_W-1:0];
        mdr_load_bus = mdr_in;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  mem_interface_mdr_reg u_mdr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_bus (mdr_load_bus),
    .bus_in   (bus_in),
    .load_mem (mdr_load_mem),
    .mem_rdata(mem_rdata),
    .data_q   (mdr_q)
  );

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & we_q;
  assign busy      = mem_req;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// tb/tb_mem_interface.sv - randomized self-checking bench for mem_interface
module tb_mem_interface;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] bus_in, mem_rdata;
  logic        mar_in, mdr_in, read, write, mem_ack;
  logic [31:0] mdr_q, mem_wdata;
  logic [8:0]  mem_addr;
  logic        mem_req, mem_we, busy, done, err;

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  m_mar;
  logic [31:0] m_mdr;
  logic        m_err;

  mem_interface #(.ADDR_W(9), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .read(read), .write(write), .mdr_q(mdr_q), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic load_regs(input logic lm, input logic ld, input logic [31:0] v);
    bus_in = v; mar_in = lm; mdr_in = ld;
    @(posedge clk); #1;
    mar_in = 1'b0; mdr_in = 1'b0;
    if (lm) m_mar = v[8:0];
    if (ld) m_mdr = v;
  endtask

  // Plays the memory side of one transaction and records what was observed.
  task automatic run_txn(input logic rd, input logic wr, input int ack_cycle, input logic [31:0] rdata,
                         input logic noise, input logic poke,
                         output int reqn, output int donen, output int busyn,
                         output logic [8:0] addr0, output logic addr_moved, output logic we0,
                         output logic we_moved, output logic [31:0] wdata0,
                         output logic [31:0] mdr_done, output logic fin);
    reqn = 0; donen = 0; busyn = 0; addr0 = '0; addr_moved = 1'b0; we0 = 1'b0;
    we_moved = 1'b0; wdata0 = '0; mdr_done = '0; fin = 1'b0;
    read = rd; write = wr;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0; mem_ack = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
      if (noise) mem_rdata = $urandom;
      if (busy) busyn++;
      if (mem_req) begin
        reqn++;
        if (reqn == 1) begin
          addr0 = mem_addr; we0 = mem_we; wdata0 = mem_wdata;
        end else begin
          if (mem_addr !== addr0 || mem_wdata !== wdata0) addr_moved = 1'b1;
          if (mem_we !== we0) we_moved = 1'b1;
        end
        if (reqn == ack_cycle) begin mem_ack = 1'b1; mem_rdata = rdata; end
        if (poke) begin mar_in = 1'b1; mdr_in = 1'b1; bus_in = 32'hFFFF_FFFF; end
      end else begin
        if (noise) mem_ack = 1'($urandom);
        if (done) begin
          donen++; mdr_done = mdr_q;
        end else if (reqn > 0) begin
          fin = 1'b1;
          break;
        end
      end
    end
    mem_ack = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus_in = '0; mar_in = 0; mdr_in = 0; read = 0; write = 0;
    mem_ack = 0; mem_rdata = '0;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (mdr_q !== 32'h0) begin fails++; $display("FAIL reset_mdr got %h want 0", mdr_q); end
    tests++; if (mem_addr !== 9'h0) begin fails++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    tests++; if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin fails++;
      $display("FAIL reset_ctl got req/we/busy/done/err=%b want 00000", {mem_req, mem_we, busy, done, err}); end
  endtask

  task automatic test_read();
    int rq, dn, bz; logic [8:0] a0; logic am, w0, wm, fin; logic [31:0] wd, md;
    bus_in = 32'h0000_0042; mar_in = 1'b1; m_mar = 9'h042;
    run_txn(1'b1, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, rq, dn, bz, a0, am, w0, wm, wd, md, fin);
    m_mdr = 32'hDEAD_BEEF; m_err = 1'b0;
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL read_finish got %b want 1", fin); end
    tests++; if (a0 !== m_mar || am !== 1'b0) begin fails++; $display("FAIL read_addr got %h moved=%b want %h", a0, am, m_mar); end
    tests++; if (w0 !== 1'b0) begin fails++; $display("FAIL read_we got %b want 0", w0); end
    tests++; if (rq !== 3 || bz !== 3) begin fails++; $display("FAIL read_busy got req=%0d busy=%0d want 3", rq, bz); end
    tests++; if (dn !== 1 || md !== m_mdr) begin fails++; $display("FAIL read_done got %0d pulses mdr=%h want 1 %h", dn, md, m_mdr); end
    tests++; if (mdr_q !== m_mdr || err !== 1'b0) begin fails++; $display("FAIL read_end got mdr=%h err=%b want %h 0", mdr_q, err, m_mdr); end
  endtask

  task automatic test_write();
    int rq, dn, bz; logic [8:0] a0; logic am, w0, wm, fin; logic [31:0] wd, md;
    load_regs(1'b1, 1'b0, 32'h0000_0010);
    load_regs(1'b0, 1'b1, 32'h1234_5678);
    run_txn(1'b0, 1'b1, 1, 32'hA5A5_A5A5, 1'b0, 1'b0, rq, dn, bz, a0, am, w0, wm, wd, md, fin);
    tests++; if (w0 !== 1'b1 || wm !== 1'b0) begin fails++; $display("FAIL write_we got %b moved=%b want 1", w0, wm); end
    tests++; if (wd !== 32'h1234_5678 || a0 !== 9'h010) begin fails++; $display("FAIL write_bus got %h @%h want 12345678 @010", wd, a0); end
    tests++; if (rq !== 1 || dn !== 1) begin fails++; $display("FAIL write_done got req=%0d done=%0d want 1 1", rq, dn); end
    tests++; if (mdr_q !== 32'h1234_5678) begin fails++; $display("FAIL write_mdr got %h want 12345678", mdr_q); end
  endtask

  task automatic test_timeout();
    int rq, dn, bz; logic [8:0] a0; logic am, w0, wm, fin; logic [31:0] wd, md;
    run_txn(1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0, rq, dn, bz, a0, am, w0, wm, wd, md, fin);
    m_err = 1'b1;
    tests++; if (rq !== TMO || dn !== 0) begin fails++; $display("FAIL timeout_len got req=%0d done=%0d want %0d 0", rq, dn, TMO); end
    tests++; if (err !== 1'b1 || mdr_q !== m_mdr) begin fails++; $display("FAIL timeout_err got err=%b mdr=%h want 1 %h", err, mdr_q, m_mdr); end
    run_txn(1'b1, 1'b0, 1, 32'h0BEE_F00D, 1'b0, 1'b0, rq, dn, bz, a0, am, w0, wm, wd, md, fin);
    m_err = 1'b0; m_mdr = 32'h0BEE_F00D;
    tests++; if (err !== 1'b0 || mdr_q !== m_mdr) begin fails++; $display("FAIL timeout_clear got err=%b mdr=%h want 0 %h", err, mdr_q, m_mdr); end
  endtask

  task automatic test_ack_last();
    int rq, dn, bz; logic [8:0] a0; logic am, w0, wm, fin; logic [31:0] wd, md;
    run_txn(1'b1, 1'b0, TMO, 32'h5555_AAAA, 1'b0, 1'b0, rq, dn, bz, a0, am, w0, wm, wd, md, fin);
    m_mdr = 32'h5555_AAAA;
    tests++; if (rq !== TMO || dn !== 1 || err !== 1'b0) begin fails++;
      $display("FAIL ack_last got req=%0d done=%0d err=%b want %0d 1 0", rq, dn, err, TMO); end
    tests++; if (mdr_q !== m_mdr) begin fails++; $display("FAIL ack_last_mdr got %h want %h", mdr_q, m_mdr); end
  endtask

  task automatic test_both();
    read = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; m_err = 1'b1;
    tests++; if (err !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL both_start got err=%b req=%b want 1 0", err, mem_req); end
    @(posedge clk); #1;
    tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL both_idle got req=%b busy=%b want 0 0", mem_req, busy); end
  endtask

  task automatic test_freeze();
    int rq, dn, bz; logic [8:0] a0; logic am, w0, wm, fin; logic [31:0] wd, md;
    load_regs(1'b1, 1'b0, 32'h0000_0155);
    load_regs(1'b0, 1'b1, 32'h0BAD_F00D);
    run_txn(1'b0, 1'b1, 4, 32'h0, 1'b0, 1'b1, rq, dn, bz, a0, am, w0, wm, wd, md, fin);
    tests++; if (a0 !== 9'h155 || am !== 1'b0) begin fails++; $display("FAIL freeze_addr got %h moved=%b want 155", a0, am); end
    tests++; if (mem_addr !== m_mar || mdr_q !== m_mdr) begin fails++;
      $display("FAIL freeze_regs got %h %h want %h %h", mem_addr, mdr_q, m_mar, m_mdr); end
    m_err = 1'b0;
  endtask

  task automatic test_async_reset();
    load_regs(1'b1, 1'b1, 32'h0000_00AA);
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL areset_pre got req=%b want 1", mem_req); end
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL areset_req got req=%b busy=%b want 0 0", mem_req, busy); end
    tests++; if (mem_addr !== 9'h0 || mdr_q !== 32'h0) begin fails++; $display("FAIL areset_regs got %h %h want 0 0", mem_addr, mdr_q); end
    @(posedge clk); #1;
    reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_CAFE;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    tests++; if ({mem_req, done, err} !== 3'b0 || mdr_q !== 32'h0) begin fails++;
      $display("FAIL areset_late_ack got req/done/err=%b mdr=%h want 000 0", {mem_req, done, err}, mdr_q); end
  endtask

  task automatic test_random();
    int rq, dn, bz, ack; logic [8:0] a0; logic am, w0, wm, fin, rd, ok; logic [31:0] wd, md, rdat, pre;
    for (int i = 0; i < 24; i++) begin
      if ($urandom % 2) load_regs(1'b1, 1'b0, $urandom);
      if ($urandom % 2) load_regs(1'b0, 1'b1, $urandom);
      rd = 1'($urandom); ack = $urandom_range(1, TMO + 2); rdat = $urandom; pre = m_mdr;
      run_txn(rd, ~rd, ack, rdat, 1'b1, 1'b0, rq, dn, bz, a0, am, w0, wm, wd, md, fin);
      ok = (ack <= TMO);
      if (ok && rd) m_mdr = rdat;
      m_err = ~ok;
      tests++; if (fin !== 1'b1 || rq !== (ok ? ack : TMO) || bz !== rq || dn !== (ok ? 1 : 0)) begin fails++;
        $display("FAIL rand%0d_seq got fin=%b req=%0d busy=%0d done=%0d want req=%0d ok=%b", i, fin, rq, bz, dn, ok ? ack : TMO, ok); end
      tests++; if (a0 !== m_mar || am !== 1'b0 || w0 !== ~rd || wm !== 1'b0 || wd !== pre) begin fails++;
        $display("FAIL rand%0d_bus got addr=%h we=%b wdata=%h want %h %b %h", i, a0, w0, wd, m_mar, ~rd, pre); end
      tests++; if (mdr_q !== m_mdr || err !== m_err) begin fails++;
        $display("FAIL rand%0d_end got mdr=%h err=%b want %h %b", i, mdr_q, err, m_mdr, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_last();
    test_both();
    test_freeze();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
